mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped transmit-only UART on the single-cycle core's data bus, downstream of the core.
- Snoops `memwrite`/`dataadr`/`writedata` from `top` and buffers byte stores in a small FIFO.
- Serialises buffered bytes 8N1 on a `tx` line.
- Provides a readable status word so firmware can poll before storing, and lets the testbench observe program output serially.

Parameters:
- `BASE_ADDR`, 32'h0000_0100, byte address of the DATA register; the STATUS register is at `BASE_ADDR`+4.
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 4, number of byte entries; must be a power of two, ≥2.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `memwrite` input 1: core store strobe.
- `dataadr` input 32: core data address (ALU result).
- `writedata` input 32: core store data.
- `readdata` output 32: combinational status read data; zero when not addressed.
- `tx` output 1: serial line, registered, idle high.
- `busy` output 1: high while a frame is in progress or the FIFO is non-empty.
- `irq_empty` output 1: high when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset values:
  - `tx`=1, `busy`=0, `irq_empty`=1.
  - FIFO empty, FSM=IDLE, overflow flag=0, baud counter=0, bit index=0.
- Decode:
  - `wr_data` = `memwrite` & (`dataadr`==`BASE_ADDR`).
  - `wr_stat` = `memwrite` & (`dataadr`==`BASE_ADDR`+4).
  - Exact 32-bit compare; all other addresses are ignored.
- DATA write:
  - Pushes `writedata[7:0]` at the clock edge; `writedata[31:8]` is ignored.
  - If the FIFO is full and no pop occurs that cycle: the byte is dropped and the sticky `ovf` flag is set.
- STATUS write:
  - Clears `ovf` regardless of data.
  - If the same edge would set `ovf`, setting wins. This cannot occur from a single store; it is documented for completeness.
- `readdata`:
  - When `dataadr`==`BASE_ADDR`+4: {28'b0, `ovf`, empty, full, `busy`} (bit0=`busy`, bit1=full, bit2=empty, bit3=`ovf`).
  - Otherwise 32'b0.
  - Purely combinational, no `memwrite` qualification.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop into the shift register, go to START, and drive `tx` low from the next edge.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1; reaching terminal count advances the bit or state.
  - Reloads to 0 on every state change.
- Latency and frame timing:
  - Store at edge k into an empty FIFO with FSM IDLE: pop at edge k+1, `tx` falls at edge k+1.
  - A frame is exactly 10×`CLKS_PER_BIT` cycles.
  - The next queued byte starts one cycle after STOP ends (one IDLE cycle between frames).
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - When full, this push is accepted and `ovf` stays unchanged.
- FIFO pointers are `log2(FIFO_DEPTH)`+1 bits; wrap naturally. full = MSBs differ and LSBs equal.
- `busy` = (FSM≠IDLE) | ~empty.
- `irq_empty` = (FSM==IDLE) & empty.
- Reset mid-frame: `tx` returns high asynchronously, the frame is aborted, and queued bytes are discarded.

Decomposition:
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`.
  - Localparams `STAT_OFFSET`=4 and status bit indices `STAT_BUSY`=0, `STAT_FULL`=1, `STAT_EMPTY`=2, `STAT_OVF`=3.
- Sub-module `sync_fifo` (`WIDTH`=8, `DEPTH`=`FIFO_DEPTH`):
  - Ports: `clk`, `reset`, push, `din`, pop, `dout`, full, empty.
  - `dout` shows the head entry combinationally.
- The top level holds decode, status mux, FSM, baud counter and shifter.

Test Plan:
- Reset held 22 ns then released, no stores → `tx`=1, `busy`=0, `irq_empty`=1, `readdata` at 0x104 = 32'h4.
- Store 71 (0x47) to 0x100 with `CLKS_PER_BIT`=4 → `tx` low for 4 cycles, then bits 1,1,1,0,0,0,1,0 for 4 cycles each, then high for 4. `busy` falls 40 cycles after the pop.
- 5 back-to-back stores 0x11..0x15 to 0x100 while the first frame is in flight → all 5 transmitted in order with a 1-cycle gap between frames, `ovf`=0.
- Fill FIFO (4 bytes) while the FSM is mid-frame, store a 6th byte → byte dropped, status = 32'hB (`ovf`, full, `busy`). Store to 0x104 → `ovf` clears.
- Store to 0x54 (84) with data 71 → no FIFO push, `tx` stays 1, `readdata`=0.
- Assert `reset` in the middle of DATA bit 3 → `tx`=1 immediately, status reads 32'h4 after release, and no residual frame follows.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the memory-mapped transmit UART.
//   uart_state_t : serialiser FSM states
//   STAT_OFFSET  : byte offset of the STATUS register from the DATA register
//   STAT_*       : bit positions inside the STATUS read word
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [31:0] STAT_OFFSET = 32'd4;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head-of-queue output.
//   clk, reset : clock and asynchronous active-high reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge; the write lands in the slot the reader is vacating.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible once the pointers move.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// ----------------------------------------------------------------------------
// mmio_uart_tx
// Transmit-only UART snooping the core's data bus. Byte stores to BASE_ADDR
// are queued and sent 8N1 on tx; BASE_ADDR+4 is a status register.
//   clk, reset          : clock and asynchronous active-high reset
//   memwrite            : core store strobe
//   dataadr, writedata  : core store address / data
//   readdata            : status word when dataadr hits STATUS, else zero
//   tx                  : registered serial line, idle high
//   busy                : frame in progress or bytes queued
//   irq_empty           : nothing queued and serialiser idle
// Status word: bit0 busy, bit1 full, bit2 empty, bit3 sticky overflow.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx,
    output logic        busy,
    output logic        irq_empty
);

    localparam int          BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + STAT_OFFSET;

    // Address decode
    logic wr_data;
    logic wr_stat;
    logic stat_sel;

    assign wr_data  = memwrite & (dataadr == BASE_ADDR);
    assign wr_stat  = memwrite & (dataadr == STAT_ADDR);
    assign stat_sel = (dataadr == STAT_ADDR);

    // Only the low byte of a DATA store is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];

    // Byte queue
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (writedata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Serialiser state
    uart_state_t state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic          baud_done;

    assign baud_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                    baud_d   = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // The line level is derived from the next state so tx changes on the
    // same edge as the state it belongs to.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Overflow: a DATA store that the FIFO cannot accept. Clearing via a
    // STATUS store loses to a simultaneous set.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_stat) begin
            ovf_d = 1'b0;
        end
        if (wr_data && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) | ~fifo_empty;
    assign irq_empty = (state_q == IDLE) & fifo_empty;

    always_comb begin
        readdata = 32'h0;
        if (stat_sel) begin
            readdata[STAT_BUSY]  = busy;
            readdata[STAT_FULL]  = fifo_full;
            readdata[STAT_EMPTY] = fifo_empty;
            readdata[STAT_OVF]   = ovf_q;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] DATA_ADDR = 32'h0000_0100;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx;
    logic        busy;
    logic        irq_empty;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR    (DATA_ADDR),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx        (tx),
        .busy      (busy),
        .irq_empty (irq_empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Call just after a rising edge; the store is taken on the next edge.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        @(posedge clk);
        #1;
        $display("store addr=0x%08h data=0x%08h", addr, data);
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    // Checks one complete frame. exp_wait is the number of falling clock
    // edges until the start bit is first seen; every bit must hold for all
    // four cycles. After the stop bit the line must be idle for one cycle.
    task automatic check_frame(input logic [7:0] b, input int exp_wait, input logic exp_busy_after);
        int         waited;
        logic [3:0] s;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 100);
        check_eq($sformatf("start_lat_%02h", b), waited, exp_wait);
        check_eq($sformatf("busy_mid_%02h", b), {31'b0, busy}, 32'd1);
        s[0] = tx;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            s[i] = tx;
        end
        check_eq($sformatf("start_bit_%02h", b), {28'b0, s}, 32'h0);
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                s[i] = tx;
            end
            check_eq($sformatf("bit%0d_%02h", j, b), {28'b0, s}, {28'b0, {4{b[j]}}});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s[i] = tx;
        end
        check_eq($sformatf("stop_bit_%02h", b), {28'b0, s}, 32'hF);
        @(negedge clk);
        check_eq($sformatf("gap_tx_%02h", b), {31'b0, tx}, 32'd1);
        check_eq($sformatf("busy_after_%02h", b), {31'b0, busy}, {31'b0, exp_busy_after});
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check_eq(tag, bad, 0);
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;

        // Reset state
        #22;
        reset = 1'b0;
        #1;
        check_eq("rst_tx", {31'b0, tx}, 32'd1);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_irq", {31'b0, irq_empty}, 32'd1);
        dataadr = STAT_ADDR;
        #1;
        check_eq("rst_status", readdata, 32'h4);
        dataadr = DATA_ADDR;
        #1;
        check_eq("rd_data_addr", readdata, 32'h0);
        dataadr = 32'h0;
        @(posedge clk);
        #1;

        // Single byte 0x47; upper data bits must be ignored
        store(DATA_ADDR, 32'hABCD_EF47);
        check_frame(8'h47, 2, 1'b0);
        check_eq("irq_after_47", {31'b0, irq_empty}, 32'd1);
        @(posedge clk);
        #1;

        // Five back-to-back stores, first one already in flight
        store(DATA_ADDR, 32'h11);
        fork
            begin
                for (int i = 2; i <= 5; i++) store(DATA_ADDR, 32'h10 + i);
            end
            begin
                check_frame(8'h11, 2, 1'b1);
                check_frame(8'h12, 1, 1'b1);
                check_frame(8'h13, 1, 1'b1);
                check_frame(8'h14, 1, 1'b1);
                check_frame(8'h15, 1, 1'b0);
            end
        join
        dataadr = STAT_ADDR;
        #1;
        check_eq("status_after_burst", readdata, 32'h4);
        dataadr = 32'h0;
        @(posedge clk);
        #1;

        // Overflow: fill the FIFO behind a frame, sixth byte dropped
        store(DATA_ADDR, 32'h21);
        fork
            begin
                for (int i = 2; i <= 6; i++) store(DATA_ADDR, 32'h20 + i);
                dataadr = STAT_ADDR;
                #1;
                check_eq("status_ovf", readdata, 32'hB);
                store(STAT_ADDR, 32'hFFFF_FFFF);
                dataadr = STAT_ADDR;
                #1;
                check_eq("status_ovf_clr", readdata, 32'h3);
                dataadr = 32'h0;
            end
            begin
                check_frame(8'h21, 2, 1'b1);
                check_frame(8'h22, 1, 1'b1);
                check_frame(8'h23, 1, 1'b1);
                check_frame(8'h24, 1, 1'b1);
                check_frame(8'h25, 1, 1'b0);
            end
        join
        idle_watch("no_dropped_byte", 60);
        @(posedge clk);
        #1;

        // Store to an unmapped address
        memwrite  = 1'b1;
        dataadr   = 32'h0000_0054;
        writedata = 32'd71;
        #1;
        check_eq("rd_unmapped", readdata, 32'h0);
        @(posedge clk);
        #1;
        $display("store addr=0x00000054 data=0x00000047");
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
        check_eq("unmapped_busy", {31'b0, busy}, 32'd0);
        check_eq("unmapped_irq", {31'b0, irq_empty}, 32'd1);
        idle_watch("unmapped_idle", 50);
        @(posedge clk);
        #1;

        // Reset during DATA bit 3 of 0xA5 (that bit is 0)
        store(DATA_ADDR, 32'hA5);
        repeat (17) @(posedge clk);
        #2;
        check_eq("pre_rst_tx", {31'b0, tx}, 32'd0);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_tx", {31'b0, tx}, 32'd1);
        check_eq("mid_rst_busy", {31'b0, busy}, 32'd0);
        check_eq("mid_rst_irq", {31'b0, irq_empty}, 32'd1);
        #10;
        @(negedge clk);
        reset = 1'b0;
        dataadr = STAT_ADDR;
        #1;
        check_eq("post_rst_status", readdata, 32'h4);
        dataadr = 32'h0;
        idle_watch("no_residual_frame", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
